// File: rtl/usb_kbd_event_queue_if.sv
// Bundle between the HID report source / event consumer and the keyboard
// event queue. The slave modport is the queue's view; master is the host view.
//
// Handshake: report_stb is a one-cycle qualifier for typ/key_modifiers/key1..4
// with no back-pressure. On the event side evt_data holds the head event
// whenever evt_valid is high; the head is consumed on a rising edge where both
// evt_valid and evt_rd are high, and evt_rd while evt_valid is low is ignored.
interface usb_kbd_event_queue_if #(
  parameter int DEPTH = 16
) ();
  logic                     report_stb;
  logic [1:0]               typ;
  logic [7:0]               key_modifiers;
  logic [7:0]               key1;
  logic [7:0]               key2;
  logic [7:0]               key3;
  logic [7:0]               key4;
  logic                     evt_valid;
  logic [8:0]               evt_data;
  logic                     evt_rd;
  logic [$clog2(DEPTH):0]   evt_count;
  logic                     busy;
  logic                     ovf;
  logic                     clr_ovf;

  modport master (
    output report_stb, typ, key_modifiers, key1, key2, key3, key4, evt_rd, clr_ovf,
    input  evt_valid, evt_data, evt_count, busy, ovf
  );

  modport slave (
    input  report_stb, typ, key_modifiers, key1, key2, key3, key4, evt_rd, clr_ovf,
    output evt_valid, evt_data, evt_count, busy, ovf
  );
endinterface

// File: rtl/usb_kbd_event_queue.sv
// USB keyboard event queue: diffs successive HID keyboard report snapshots
// into break/make events ({make, usage}) and buffers them in a FWFT FIFO.
// A scan takes 25 busy cycles: 12 BRK indices, 12 MAKE indices, 1 COMMIT.
// The interface DEPTH parameter must match the module DEPTH parameter.
module usb_kbd_event_queue #(
  parameter int DEPTH = 16
) (
  input  logic                 wb_clk,
  input  logic                 sys_rst,
  usb_kbd_event_queue_if.slave bus,
  output logic [1:0]           dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [3:0] LAST_IDX = 4'd11;

  // IDLE encodes as 2'd0 on dbg_state.
  typedef enum logic [1:0] {IDLE, BRK, MAKE, COMMIT} state_t;

  // keys[0] is key1 ... keys[3] is key4.
  typedef struct packed {
    logic [7:0]      mods;
    logic [3:0][7:0] keys;
  } snap_t;

  state_t      state, state_nx;
  logic [3:0]  idx, idx_nx;
  logic        start_scan;
  snap_t       prev_s, cur_s, pend_s, in_s, acc_s;
  logic        pend_valid;
  logic [1:0]  typ_q;
  logic        rollover, release_all, accept;

  snap_t       scan_a, scan_b;
  logic        mk, hit, in_b, dup;
  logic [7:0]  key_k, code;
  logic        push;
  logic [8:0]  push_data;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, full, do_pop, do_push, drop;

  // Report qualification: keyboard strobes, rollover filtering, release-all on typ leaving 1.
  always_comb begin
    in_s.mods = bus.key_modifiers;
    in_s.keys = {bus.key4, bus.key3, bus.key2, bus.key1};
    rollover  = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (in_s.keys[j] inside {8'h01, 8'h02, 8'h03}) rollover = 1'b1;
    end
    release_all = (typ_q == 2'd1) && (bus.typ != 2'd1);
    accept      = release_all || (bus.report_stb && (bus.typ == 2'd1) && !rollover);
    acc_s       = release_all ? '0 : in_s;
  end

  // Scan sequencing: IDLE/COMMIT start a new scan from a fresh or pending report.
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    start_scan = 1'b0;
    case (state)
      IDLE, COMMIT: begin
        if (accept || pend_valid) begin
          state_nx   = BRK;
          idx_nx     = '0;
          start_scan = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      BRK: begin
        if (idx == LAST_IDX) begin
          state_nx = MAKE;
          idx_nx   = '0;
        end else begin
          idx_nx = idx + 4'd1;
        end
      end
      MAKE: begin
        if (idx == LAST_IDX) begin
          state_nx = COMMIT;
          idx_nx   = '0;
        end else begin
          idx_nx = idx + 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and scan index registers.
  always_ff @(posedge wb_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Snapshot registers: cur loads at scan start, prev follows cur on COMMIT,
  // reports arriving mid-scan park in the pending slot (latest wins).
  always_ff @(posedge wb_clk) begin
    if (sys_rst) begin
      prev_s     <= '0;
      cur_s      <= '0;
      pend_s     <= '0;
      pend_valid <= 1'b0;
      typ_q      <= '0;
    end else begin
      typ_q <= bus.typ;
      if (state == COMMIT) prev_s <= cur_s;
      if (start_scan) begin
        cur_s      <= accept ? acc_s : pend_s;
        pend_valid <= 1'b0;
      end else if (accept && (state != IDLE)) begin
        pend_s     <= acc_s;
        pend_valid <= 1'b1;
      end
    end
  end

  // One diff step per cycle: BRK looks for entries leaving (prev vs cur),
  // MAKE for entries arriving (cur vs prev). Repeated keys report once.
  always_comb begin
    scan_a = prev_s;
    scan_b = cur_s;
    mk     = 1'b0;
    hit    = 1'b0;
    code   = 8'h00;
    if (state == MAKE) begin
      scan_a = cur_s;
      scan_b = prev_s;
      mk     = 1'b1;
    end
    key_k = scan_a.keys[idx[1:0]];
    in_b  = 1'b0;
    dup   = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (scan_b.keys[j] == key_k) in_b = 1'b1;
      if ((j < int'(idx[1:0])) && (scan_a.keys[j] == key_k)) dup = 1'b1;
    end
    if (!idx[3]) begin
      hit  = scan_a.mods[idx[2:0]] & ~scan_b.mods[idx[2:0]];
      code = {5'b11100, idx[2:0]};
    end else begin
      hit  = (key_k != 8'h00) && !in_b && !dup;
      code = key_k;
    end
    push      = ((state == BRK) || (state == MAKE)) && hit;
    push_data = {mk, code};
  end

  // FIFO control: a pop frees the slot for a same-cycle push when full.
  always_comb begin
    empty   = (count == '0);
    full    = (count == FULL_CNT);
    do_pop  = bus.evt_rd && !empty;
    do_push = push && (!full || do_pop);
    drop    = push && full && !do_pop;
  end

  // FIFO storage; contents need no reset since occupancy gates the output.
  always_ff @(posedge wb_clk) begin
    if (!sys_rst && do_push) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers, occupancy and sticky overflow (a drop beats clr_ovf).
  always_ff @(posedge wb_clk) begin
    if (sys_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      bus.ovf <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (drop)             bus.ovf <= 1'b1;
      else if (bus.clr_ovf) bus.ovf <= 1'b0;
    end
  end

  // Output drive: head is forced to zero while the FIFO is empty.
  always_comb begin
    bus.evt_valid = !empty;
    bus.evt_data  = empty ? 9'h000 : mem[rd_ptr];
    bus.evt_count = count;
    bus.busy      = (state != IDLE);
    dbg_state     = state;
  end

endmodule

// File: tb/tb_usb_kbd_event_queue.sv
// Bench for usb_kbd_event_queue: directed scenarios plus random reports,
// checked against a set-based reference of keyboard make/break events.
module tb_usb_kbd_event_queue;

  typedef struct packed {
    logic [7:0]      mods;
    logic [3:0][7:0] keys;
  } snap_t;

  logic       wb_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [1:0] dbg_state, dbg_state4;

  usb_kbd_event_queue_if #(.DEPTH(16)) bus ();
  usb_kbd_event_queue_if #(.DEPTH(4))  bus4 ();

  usb_kbd_event_queue #(.DEPTH(16)) dut (
    .wb_clk(wb_clk), .sys_rst(sys_rst), .bus(bus), .dbg_state(dbg_state));
  usb_kbd_event_queue #(.DEPTH(4)) dut4 (
    .wb_clk(wb_clk), .sys_rst(sys_rst), .bus(bus4), .dbg_state(dbg_state4));

  int         errors = 0;
  int         checks = 0;
  logic [8:0] exp_q[$];
  snap_t      m_prev;
  logic [1:0] m_typ;
  int         n;

  // Clock and watchdog.
  always #5 wb_clk = ~wb_clk;
  initial begin
    #400000;
    $display("FAIL watchdog: run did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard compare.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic snap_t make_snap(input logic [7:0] m, input logic [7:0] k1,
                                      input logic [7:0] k2, input logic [7:0] k3,
                                      input logic [7:0] k4);
    snap_t s;
    s.mods = m;
    s.keys = {k4, k3, k2, k1};
    return s;
  endfunction

  // Reference model: events are set differences of modifiers and keys.
  function automatic logic has_key(input snap_t s, input logic [7:0] k);
    for (int j = 0; j < 4; j++) if (s.keys[j] == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic is_rollover(input snap_t s);
    for (int j = 0; j < 4; j++) if (s.keys[j] >= 8'h01 && s.keys[j] <= 8'h03) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_side(input snap_t from_s, input snap_t to_s, input logic make);
    logic [255:0] seen;
    logic [7:0]   k;
    seen = '0;
    for (int i = 0; i < 8; i++)
      if (from_s.mods[i] && !to_s.mods[i]) exp_q.push_back({make, 8'hE0 | 8'(i)});
    for (int i = 0; i < 4; i++) begin
      k = from_s.keys[i];
      if (k != 8'h00 && !seen[k]) begin
        seen[k] = 1'b1;
        if (!has_key(to_s, k)) exp_q.push_back({make, k});
      end
    end
  endfunction

  function automatic void model_report(input snap_t s);
    model_side(m_prev, s, 1'b0);
    model_side(s, m_prev, 1'b1);
    m_prev = s;
  endfunction

  // Returns the expected number of busy cycles for this strobe.
  function automatic int model_send(input snap_t s, input logic [1:0] t);
    int busy_n;
    busy_n = 0;
    if (m_typ == 2'd1 && t != 2'd1) begin
      model_report('0);
      busy_n = 25;
    end else if (t == 2'd1 && !is_rollover(s)) begin
      model_report(s);
      busy_n = 25;
    end
    m_typ = t;
    return busy_n;
  endfunction

  // Driver tasks.
  task automatic send(input snap_t s, input logic [1:0] t);
    @(negedge wb_clk);
    bus.report_stb = 1'b1;
    bus.typ = t;
    bus.key_modifiers = s.mods;
    bus.key1 = s.keys[0];
    bus.key2 = s.keys[1];
    bus.key3 = s.keys[2];
    bus.key4 = s.keys[3];
    @(negedge wb_clk);
    bus.report_stb = 1'b0;
  endtask

  task automatic send4(input snap_t s);
    @(negedge wb_clk);
    bus4.report_stb = 1'b1;
    bus4.typ = 2'd1;
    bus4.key_modifiers = s.mods;
    bus4.key1 = s.keys[0];
    bus4.key2 = s.keys[1];
    bus4.key3 = s.keys[2];
    bus4.key4 = s.keys[3];
    @(negedge wb_clk);
    bus4.report_stb = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 200) begin
      cnt++;
      @(negedge wb_clk);
    end
    check("wait_idle", 32'(bus.busy), 0);
  endtask

  task automatic wait_idle4(output int cnt);
    cnt = 0;
    while (bus4.busy && cnt < 200) begin
      cnt++;
      @(negedge wb_clk);
    end
    check("wait_idle4", 32'(bus4.busy), 0);
  endtask

  task automatic drain(input string tag);
    int          guard;
    logic [31:0] want;
    guard = 0;
    check({tag, "_count"}, 32'(bus.evt_count), exp_q.size());
    while (bus.evt_valid && guard < 40) begin
      want = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
      check({tag, "_event"}, 32'(bus.evt_data), want);
      bus.evt_rd = 1'b1;
      @(negedge wb_clk);
      guard++;
    end
    bus.evt_rd = 1'b0;
    check({tag, "_missing"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic drain4(input string tag);
    int          guard;
    logic [31:0] want;
    guard = 0;
    check({tag, "_count"}, 32'(bus4.evt_count), exp_q.size());
    while (bus4.evt_valid && guard < 10) begin
      want = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
      check({tag, "_event"}, 32'(bus4.evt_data), want);
      bus4.evt_rd = 1'b1;
      @(negedge wb_clk);
      guard++;
    end
    bus4.evt_rd = 1'b0;
    check({tag, "_missing"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"},  32'(bus.evt_valid), 0);
    check({tag, "_data"},   32'(bus.evt_data), 0);
    check({tag, "_count"},  32'(bus.evt_count), 0);
    check({tag, "_busy"},   32'(bus.busy), 0);
    check({tag, "_ovf"},    32'(bus.ovf), 0);
    check({tag, "_state"},  32'(dbg_state), 0);
    check({tag, "_valid4"}, 32'(bus4.evt_valid), 0);
    check({tag, "_data4"},  32'(bus4.evt_data), 0);
    check({tag, "_count4"}, 32'(bus4.evt_count), 0);
    check({tag, "_busy4"},  32'(bus4.busy), 0);
    check({tag, "_ovf4"},   32'(bus4.ovf), 0);
  endtask

  initial begin
    snap_t a, b, c, z;
    bus.report_stb = 1'b0;  bus.typ = 2'd0;  bus.key_modifiers = 8'h00;
    bus.key1 = 8'h00; bus.key2 = 8'h00; bus.key3 = 8'h00; bus.key4 = 8'h00;
    bus.evt_rd = 1'b0; bus.clr_ovf = 1'b0;
    bus4.report_stb = 1'b0; bus4.typ = 2'd0; bus4.key_modifiers = 8'h00;
    bus4.key1 = 8'h00; bus4.key2 = 8'h00; bus4.key3 = 8'h00; bus4.key4 = 8'h00;
    bus4.evt_rd = 1'b0; bus4.clr_ovf = 1'b0;
    m_prev = '0;
    m_typ = 2'd0;
    z = '0;

    // Reset state.
    sys_rst = 1'b1;
    repeat (3) @(negedge wb_clk);
    sys_rst = 1'b0;
    @(negedge wb_clk);
    check_reset_values("reset");

    // Left shift + 'a': two makes, 25 busy cycles.
    void'(model_send(make_snap(8'h02, 8'h04, 8'h00, 8'h00, 8'h00), 2'd1));
    send(make_snap(8'h02, 8'h04, 8'h00, 8'h00, 8'h00), 2'd1);
    wait_idle(n);
    check("s1_busy", n, 25);
    drain("s1");

    // Release shift and 'a', press 'b'.
    void'(model_send(make_snap(8'h00, 8'h05, 8'h00, 8'h00, 8'h00), 2'd1));
    send(make_snap(8'h00, 8'h05, 8'h00, 8'h00, 8'h00), 2'd1);
    wait_idle(n);
    check("s2_busy", n, 25);
    drain("s2");

    // typ 1 -> 0 releases the held key; a later mouse strobe is ignored.
    @(negedge wb_clk);
    bus.typ = 2'd0;
    model_report('0);
    m_typ = 2'd0;
    @(negedge wb_clk);
    wait_idle(n);
    check("s3_busy", n, 25);
    drain("s3");
    check("s3_mouse_busy", model_send(make_snap(8'h00, 8'h07, 8'h00, 8'h00, 8'h00), 2'd2), 0);
    send(make_snap(8'h00, 8'h07, 8'h00, 8'h00, 8'h00), 2'd2);
    wait_idle(n);
    check("s3_mouse_n", n, 0);
    drain("s3_mouse");

    // Rollover report is discarded; a repeat of prev yields nothing.
    void'(model_send(make_snap(8'h00, 8'h04, 8'h00, 8'h00, 8'h00), 2'd1));
    send(make_snap(8'h00, 8'h04, 8'h00, 8'h00, 8'h00), 2'd1);
    wait_idle(n);
    drain("s4_make");
    void'(model_send(make_snap(8'h00, 8'h01, 8'h06, 8'h00, 8'h00), 2'd1));
    send(make_snap(8'h00, 8'h01, 8'h06, 8'h00, 8'h00), 2'd1);
    wait_idle(n);
    check("s4_rollover_busy", n, 0);
    drain("s4_rollover");
    void'(model_send(make_snap(8'h00, 8'h04, 8'h00, 8'h00, 8'h00), 2'd1));
    send(make_snap(8'h00, 8'h04, 8'h00, 8'h00, 8'h00), 2'd1);
    wait_idle(n);
    check("s4_same_busy", n, 25);
    drain("s4_same");

    // Random reports, occasional rollover codes and device-type changes.
    for (int it = 0; it < 24; it++) begin
      snap_t      s;
      logic [1:0] t;
      int         r, eb;
      s.mods = 8'($urandom_range(0, 255));
      for (int j = 0; j < 4; j++) begin
        r = $urandom_range(0, 9);
        s.keys[j] = (r < 3) ? 8'h00 : 8'(8'h01 + r);
      end
      if ($urandom_range(0, 5) == 0) s.keys[$urandom_range(0, 3)] = 8'($urandom_range(1, 3));
      t = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
      eb = model_send(s, t);
      send(s, t);
      wait_idle(n);
      check("rand_busy", n, eb);
      drain("rand");
    end

    // Three strobes in one scan: first and last processed back to back.
    void'(model_send(z, 2'd1));
    send(z, 2'd1);
    wait_idle(n);
    drain("pend_clear");
    a = make_snap(8'h10, 8'h10, 8'h00, 8'h00, 8'h00);
    b = make_snap(8'h20, 8'h11, 8'h00, 8'h00, 8'h00);
    c = make_snap(8'h40, 8'h12, 8'h10, 8'h00, 8'h00);
    void'(model_send(a, 2'd1));
    send(a, 2'd1);
    repeat (3) @(negedge wb_clk);
    send(b, 2'd1);
    repeat (5) @(negedge wb_clk);
    send(c, 2'd1);
    void'(model_send(c, 2'd1));
    wait_idle(n);
    check("pend_busy", n, 38);
    drain("pend");

    // DEPTH=4: overflow, clear, full push with pop, drop racing clr_ovf.
    send4(make_snap(8'h03, 8'h04, 8'h05, 8'h06, 8'h07));
    wait_idle4(n);
    check("d4_busy", n, 25);
    check("d4_count_full", 32'(bus4.evt_count), 4);
    check("d4_ovf_set", 32'(bus4.ovf), 1);
    @(negedge wb_clk);
    bus4.clr_ovf = 1'b1;
    @(negedge wb_clk);
    bus4.clr_ovf = 1'b0;
    check("d4_ovf_clr", 32'(bus4.ovf), 0);
    send4(z);
    bus4.evt_rd = 1'b1;
    check("d4_head0", 32'(bus4.evt_data), 9'h1E0);
    @(negedge wb_clk);
    check("d4_head1", 32'(bus4.evt_data), 9'h1E1);
    @(negedge wb_clk);
    bus4.evt_rd = 1'b0;
    check("d4_count_pushpop", 32'(bus4.evt_count), 4);
    check("d4_ovf_pushpop", 32'(bus4.ovf), 0);
    repeat (6) @(negedge wb_clk);
    bus4.clr_ovf = 1'b1;
    @(negedge wb_clk);
    bus4.clr_ovf = 1'b0;
    check("d4_ovf_clr_vs_drop", 32'(bus4.ovf), 1);
    wait_idle4(n);
    check("d4_ovf_final", 32'(bus4.ovf), 1);
    exp_q.push_back(9'h104);
    exp_q.push_back(9'h105);
    exp_q.push_back(9'h0E0);
    exp_q.push_back(9'h0E1);
    drain4("d4");

    // Reset in the middle of BRK after one break has been queued.
    send(z, 2'd1);
    repeat (8) @(negedge wb_clk);
    check("midbrk_count", 32'(bus.evt_count), 1);
    check("midbrk_busy", 32'(bus.busy), 1);
    sys_rst = 1'b1;
    @(negedge wb_clk);
    check_reset_values("midbrk_reset");
    sys_rst = 1'b0;
    m_prev = '0;
    m_typ = 2'd1;
    exp_q.delete();

    // Normal operation after reset.
    void'(model_send(make_snap(8'h00, 8'h04, 8'h00, 8'h00, 8'h00), 2'd1));
    send(make_snap(8'h00, 8'h04, 8'h00, 8'h00, 8'h00), 2'd1);
    wait_idle(n);
    check("post_reset_busy", n, 25);
    drain("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
